// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states and the register map
// of the clock-counter slave.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  localparam logic [31:0] CTRL_START = 32'h0;
  localparam logic [31:0] CTRL_STOP  = 32'h4;
  localparam logic [31:0] STATUS     = 32'h8;

endpackage

// File: rtl/apb_cmd_master.sv
// APB requester: one host command at a time through SETUP/ACCESS,
// with a bounded wait-state timeout and a valid/ready response port.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              p_clk,
  input  logic              prst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_tmo,
  output logic [ADDR_W-1:0] p_addr,
  output logic              p_sel,
  output logic              p_en,
  output logic              p_write,
  output logic [DATA_W-1:0] p_wrdata,
  input  logic              p_ready,
  input  logic [DATA_W-1:0] p_rdata,
  input  logic              p_slverr
);

  localparam int TMO_W =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  apb_mst_state_e   state;
  logic [TMO_W-1:0] tmo_cnt;

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge p_clk or negedge prst_n) begin
    if (!prst_n) begin
      state     <= IDLE;
      p_sel     <= 1'b0;
      p_en      <= 1'b0;
      p_write   <= 1'b0;
      p_addr    <= '0;
      p_wrdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_addr[1:0] == 2'b00) begin
              p_addr   <= cmd_addr;
              p_write  <= cmd_write;
              p_wrdata <= cmd_wdata;
              p_sel    <= 1'b1;
              state    <= SETUP;
            end else begin
              // Misaligned: answer with an error, no bus cycle.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_tmo   <= 1'b0;
              rsp_rdata <= '0;
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          p_en    <= 1'b1;
          tmo_cnt <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (p_ready) begin
            rsp_rdata <= p_write ? '0 : p_rdata;
            rsp_err   <= p_slverr;
            rsp_tmo   <= 1'b0;
            rsp_valid <= 1'b1;
            p_sel     <= 1'b0;
            p_en      <= 1'b0;
            state     <= RESP;
          end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_tmo   <= 1'b1;
            rsp_valid <= 1'b1;
            p_sel     <= 1'b0;
            p_en      <= 1'b0;
            state     <= RESP;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: latency, wait states, timeout,
// misalignment, slave error, response back-pressure and async reset.
module tb_apb_cmd_master;

  logic        p_clk = 1'b0;
  logic        prst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_tmo;
  logic [31:0] p_addr;
  logic        p_sel;
  logic        p_en;
  logic        p_write;
  logic [31:0] p_wrdata;
  logic        p_ready;
  logic [31:0] p_rdata;
  logic        p_slverr;

  int vecs = 0;
  int errs = 0;

  always #5 p_clk = ~p_clk;

  apb_cmd_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .p_clk    (p_clk),
    .prst_n   (prst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .rsp_tmo  (rsp_tmo),
    .p_addr   (p_addr),
    .p_sel    (p_sel),
    .p_en     (p_en),
    .p_write  (p_write),
    .p_wrdata (p_wrdata),
    .p_ready  (p_ready),
    .p_rdata  (p_rdata),
    .p_slverr (p_slverr)
  );

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  // Present one command for exactly one edge (DUT assumed idle).
  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    prst_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; p_ready = 0; p_rdata = 0; p_slverr = 0;
    #3;
    vecs++;
    if ({cmd_ready, p_sel, p_en, rsp_valid} !== 4'b1000) begin
      errs++;
      $display("FAIL reset_ctrl got %b want 1000",
               {cmd_ready, p_sel, p_en, rsp_valid});
    end
    vecs++;
    if ({p_addr, p_wrdata, rsp_rdata, rsp_err, rsp_tmo, p_write}
        !== 99'd0) begin
      errs++;
      $display("FAIL reset_data addr=%h wd=%h rd=%h err=%b tmo=%b",
               p_addr, p_wrdata, rsp_rdata, rsp_err, rsp_tmo);
    end
    tick();
    tick();
    prst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    p_ready = 1'b1;
    issue(1'b1, 32'h0, 32'h1);
    vecs++;
    if ({p_sel, p_en, cmd_ready, p_write} !== 4'b1001
        || p_wrdata !== 32'h1 || p_addr !== 32'h0) begin
      errs++;
      $display("FAIL wr_setup sel/en/rdy/w=%b wd=%h want 1001 1",
               {p_sel, p_en, cmd_ready, p_write}, p_wrdata);
    end
    tick();
    vecs++;
    if ({p_sel, p_en, rsp_valid} !== 3'b110) begin
      errs++;
      $display("FAIL wr_access sel/en/v=%b want 110",
               {p_sel, p_en, rsp_valid});
    end
    tick();
    vecs++;
    if ({p_sel, p_en, rsp_valid, rsp_err, rsp_tmo} !== 5'b00100
        || rsp_rdata !== 32'h0) begin
      errs++;
      $display("FAIL wr_resp sel/en/v/e/t=%b rd=%h want 00100 0",
               {p_sel, p_en, rsp_valid, rsp_err, rsp_tmo}, rsp_rdata);
    end
    consume();
    vecs++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errs++;
      $display("FAIL wr_done v/rdy=%b want 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_wait_read();
    int n;
    p_ready = 1'b0;
    p_rdata = 32'h0;
    issue(1'b0, 32'h8, 32'hFFFF_FFFF);
    n = 1;
    tick();
    n++;
    tick();
    n++;
    vecs++;
    if ({p_sel, p_en, rsp_valid} !== 3'b110 || p_addr !== 32'h8) begin
      errs++;
      $display("FAIL rd_wait1 sel/en/v=%b addr=%h want 110 8",
               {p_sel, p_en, rsp_valid}, p_addr);
    end
    tick();
    n++;
    p_ready = 1'b1;
    p_rdata = 32'h1;
    tick();
    vecs++;
    if (!rsp_valid || n != 4 || rsp_rdata !== 32'h1 || rsp_err !== 1'b0)
    begin
      errs++;
      $display("FAIL rd_wait v=%b edges=%0d rd=%h e=%b want 1 4 1 0",
               rsp_valid, n, rsp_rdata, rsp_err);
    end
    p_ready = 1'b0;
    consume();
  endtask

  task automatic test_timeout();
    int n;
    p_ready = 1'b0;
    p_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 32'h8, 32'h0);
    tick();
    n = 0;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      tick();
      n++;
    end
    vecs++;
    if (!rsp_valid || n != 16) begin
      errs++;
      $display("FAIL tmo_cycles v=%b access=%0d want 1 16", rsp_valid, n);
    end
    vecs++;
    if ({p_sel, p_en, rsp_err, rsp_tmo} !== 4'b0011
        || rsp_rdata !== 32'h0) begin
      errs++;
      $display("FAIL tmo_resp sel/en/e/t=%b rd=%h want 0011 0",
               {p_sel, p_en, rsp_err, rsp_tmo}, rsp_rdata);
    end
    consume();
  endtask

  task automatic test_misaligned();
    p_ready = 1'b1;
    p_rdata = 32'h1234_5678;
    issue(1'b0, 32'h6, 32'h0);
    vecs++;
    if ({p_sel, rsp_valid, rsp_err, rsp_tmo, cmd_ready} !== 5'b01100
        || rsp_rdata !== 32'h0 || p_addr !== 32'h8) begin
      errs++;
      $display("FAIL misalign sel/v/e/t/rdy=%b rd=%h addr=%h want 01100",
               {p_sel, rsp_valid, rsp_err, rsp_tmo, cmd_ready},
               rsp_rdata, p_addr);
    end
    consume();
  endtask

  task automatic test_slverr();
    p_ready  = 1'b1;
    p_slverr = 1'b1;
    p_rdata  = 32'h55AA_33CC;
    issue(1'b0, 32'h4, 32'h0);
    tick();
    tick();
    vecs++;
    if ({rsp_valid, rsp_err, rsp_tmo} !== 3'b110
        || rsp_rdata !== 32'h55AA_33CC) begin
      errs++;
      $display("FAIL slverr v/e/t=%b rd=%h want 110 55aa33cc",
               {rsp_valid, rsp_err, rsp_tmo}, rsp_rdata);
    end
    p_slverr = 1'b0;
    consume();
  endtask

  task automatic test_throughput();
    int n;
    p_ready   = 1'b1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h4;
    cmd_wdata = 32'h7;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_valid && cmd_ready) n++;
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    vecs++;
    if (n != 3 || cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL throughput accepts=%0d rdy=%b want 3 1", n, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic bad;
    p_ready = 1'b1;
    issue(1'b1, 32'hC, 32'h1234);
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h4;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ({rsp_valid, rsp_err, rsp_tmo, cmd_ready, p_sel} !== 5'b10000
          || rsp_rdata !== 32'h0)
        bad = 1'b1;
      tick();
    end
    vecs++;
    if (bad || p_addr !== 32'hC) begin
      errs++;
      $display("FAIL hold_resp unstable=%b addr=%h want 0 c", bad, p_addr);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vecs++;
    if ({rsp_valid, cmd_ready, p_sel} !== 3'b010) begin
      errs++;
      $display("FAIL release v/rdy/sel=%b want 010",
               {rsp_valid, cmd_ready, p_sel});
    end
    tick();
    cmd_valid = 1'b0;
    vecs++;
    if (p_sel !== 1'b1 || p_addr !== 32'h4 || p_write !== 1'b0) begin
      errs++;
      $display("FAIL second_cmd sel=%b addr=%h w=%b want 1 4 0",
               p_sel, p_addr, p_write);
    end
    p_ready = 1'b0;
    tick();
    #2;
    prst_n = 1'b0;
    #1;
    vecs++;
    if ({p_sel, p_en, rsp_valid, cmd_ready} !== 4'b0001) begin
      errs++;
      $display("FAIL async_rst sel/en/v/rdy=%b want 0001",
               {p_sel, p_en, rsp_valid, cmd_ready});
    end
    tick();
    prst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_read();
    test_timeout();
    test_misaligned();
    test_slverr();
    test_throughput();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
